// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection, transmitter FSM states and the
// baud-divisor helper. The RX block will import this package as well.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Rounded clocks-per-bit for a given clock and baud rate.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output. Pointers carry one
// extra wrap bit so full and empty are told apart without a spare slot.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone say which
    // entries are valid, and leaving the array out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + PW'(do_push) - PW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// Buffered UART transmitter: valid/ready word input, runtime bit-period
// divisor, start / DATA_BITS / optional parity / 1-2 stop bits, LSB first.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9_600,
    parameter int          DATA_BITS  = 8,
    parameter parity_e     PARITY     = PAR_NONE,
    parameter int          STOP_BITS  = 1,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DIV_W      = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          div_load,
    input  logic [DIV_W-1:0]              div_value,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int                CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int                IW          = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0]  DEFAULT_DIV = DIV_W'(calc_div(CLK_FREQ, BAUD_RATE));
    localparam logic [DIV_W-1:0]  MIN_DIV     = DIV_W'(2);
    localparam logic [IW-1:0]     LAST_DATA   = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0]     LAST_STOP   = IW'(STOP_BITS - 1);
    localparam bit                PAR_EN      = (PARITY != PAR_NONE);

    tx_state_e              state, state_n;
    logic [DIV_W-1:0]       cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   par_bit, par_n;
    logic [DIV_W-1:0]       frame_div, frame_div_n;
    logic [DIV_W-1:0]       div_reg;
    logic                   txd_n;
    logic                   tick;
    logic                   start_frame;

    logic                   push, pop;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          count_n;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign push    = tx_valid && tx_ready && !fifo_full;
    assign count_n = fifo_count + CW'(push) - CW'(pop);
    assign tick    = (cnt == '0);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        shift_n     = shift;
        par_n       = par_bit;
        frame_div_n = frame_div;
        pop         = 1'b0;
        start_frame = 1'b0;
        if (state != ST_IDLE) cnt_n = cnt - DIV_W'(1);

        case (state)
            ST_IDLE:   start_frame = !fifo_empty;
            ST_START:  if (tick) begin
                state_n = ST_DATA;
                cnt_n   = frame_div - DIV_W'(1);
            end
            ST_DATA:   if (tick) begin
                shift_n = shift >> 1;
                cnt_n   = frame_div - DIV_W'(1);
                if (idx == LAST_DATA) begin
                    idx_n   = '0;
                    state_n = PAR_EN ? ST_PARITY : ST_STOP;
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            ST_PARITY: if (tick) begin
                state_n = ST_STOP;
                cnt_n   = frame_div - DIV_W'(1);
            end
            ST_STOP:   if (tick) begin
                if (idx == LAST_STOP) begin
                    idx_n = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) start_frame = 1'b1;
                    else             state_n     = ST_IDLE;
                end else begin
                    idx_n = idx + IW'(1);
                    cnt_n = frame_div - DIV_W'(1);
                end
            end
            default:   state_n = ST_IDLE;
        endcase

        if (start_frame) begin
            pop         = 1'b1;
            shift_n     = fifo_dout;
            par_n       = (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
            frame_div_n = div_reg;
            cnt_n       = div_reg - DIV_W'(1);
            idx_n       = '0;
            state_n     = ST_START;
        end
    end

    always_comb begin
        txd_n = 1'b1;
        case (state)
            ST_START:  txd_n = 1'b0;
            ST_DATA:   txd_n = shift[0];
            ST_PARITY: txd_n = par_bit;
            default:   txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            frame_div <= DEFAULT_DIV;
            div_reg   <= DEFAULT_DIV;
            txd       <= 1'b1;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            par_bit   <= par_n;
            frame_div <= frame_div_n;
            txd       <= txd_n;
            tx_ready  <= (count_n != CW'(FIFO_DEPTH));
            busy      <= (state != ST_IDLE) || (count_n != '0);
            if (div_load) div_reg <= (div_value < MIN_DIV) ? MIN_DIV : div_value;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: stimulus queues expected frames, a
// per-instance monitor decodes txd clock by clock and compares.
module tb_uart_tx_core;
    import uart_pkg::*;

    localparam int DIV_W = 20;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         lat_ref;
        bit         b2b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0]       tx_data_a = '0, tx_data_b = '0;
    logic             tx_valid_a = 1'b0, tx_valid_b = 1'b0;
    logic             div_load_a = 1'b0, div_load_b = 1'b0;
    logic [DIV_W-1:0] div_value_a = '0, div_value_b = '0;
    logic             tx_ready_a, tx_ready_b, txd_a, txd_b, busy_a, busy_b;
    logic [2:0]       fifo_count_a, fifo_count_b;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    uart_tx_core #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(DIV_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .div_load(div_load_a), .div_value(div_value_a), .txd(txd_a), .busy(busy_a), .fifo_count(fifo_count_a));

    uart_tx_core #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(DIV_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .div_load(div_load_b), .div_value(div_value_b), .txd(txd_b), .busy(busy_b), .fifo_count(fifo_count_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_txd(input int sel);
        return (sel == 0) ? txd_a : txd_b;
    endfunction

    function automatic int q_size(input int sel);
        return (sel == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic exp_t sb_pop(input int sel);
        if (sel == 0) return q_a.pop_front();
        return q_b.pop_front();
    endfunction

    // dut_a is 8N1, dut_b is 8E2.
    function automatic void build(input int sel, input logic [7:0] d,
                                  output logic [15:0] pat, output int nb);
        pat = '1;
        nb  = 0;
        pat[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            pat[nb] = d[i]; nb++;
        end
        if (sel == 1) begin
            pat[nb] = ^d; nb++;
        end
        pat[nb] = 1'b1; nb++;
        if (sel == 1) begin
            pat[nb] = 1'b1; nb++;
        end
    endfunction

    task automatic monitor(input int sel);
        exp_t        e;
        logic [15:0] pat;
        int          nb;
        int          start_cyc;
        int          last_end = -100;
        bit          abort;
        logic        got;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && get_txd(sel) === 1'b0) begin
                start_cyc = cycle;
                if (q_size(sel) == 0) begin
                    check($sformatf("dut%0d_unexpected_start", sel), 32'd1, 32'd0);
                    for (int i = 0; i < 50 && get_txd(sel) === 1'b0; i++) @(negedge clk);
                end else begin
                    e = sb_pop(sel);
                    if (e.lat_ref >= 0)
                        check($sformatf("dut%0d_%02h_latency", sel, e.data), start_cyc - e.lat_ref, 2);
                    if (e.b2b)
                        check($sformatf("dut%0d_%02h_gap", sel, e.data), start_cyc - last_end, 1);
                    build(sel, e.data, pat, nb);
                    abort = 1'b0;
                    for (int b = 0; b < nb && !abort; b++) begin
                        got = pat[b];
                        for (int c = 0; c < e.div; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst_n !== 1'b1) begin
                                abort = 1'b1;
                                break;
                            end
                            if (get_txd(sel) !== pat[b]) got = get_txd(sel);
                        end
                        if (!abort)
                            check($sformatf("dut%0d_%02h_bit%0d", sel, e.data, b), got, pat[b]);
                    end
                    last_end = cycle;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic load_div(input int sel, input logic [DIV_W-1:0] v);
        if (sel == 0) begin div_value_a = v; div_load_a = 1'b1; end
        else          begin div_value_b = v; div_load_b = 1'b1; end
        @(posedge clk); #2;
        div_load_a = 1'b0;
        div_load_b = 1'b0;
    endtask

    task automatic push(input int sel, input logic [7:0] d, input int dv, input bit lat, input bit b2b);
        exp_t e;
        bit   ok;
        bit   done = 1'b0;
        if (sel == 0) begin tx_data_a = d; tx_valid_a = 1'b1; end
        else          begin tx_data_b = d; tx_valid_b = 1'b1; end
        for (int i = 0; i < 1000 && !done; i++) begin
            ok = (sel == 0) ? tx_ready_a : tx_ready_b;
            @(posedge clk); #2;
            if (ok) done = 1'b1;
        end
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        check($sformatf("dut%0d_push_%02h", sel, d), done, 1);
        if (done) begin
            e.data = d; e.div = dv; e.lat_ref = lat ? cycle : -1; e.b2b = b2b;
            if (sel == 0) q_a.push_back(e);
            else          q_b.push_back(e);
        end
    endtask

    task automatic wait_idle(input int sel, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #2;
            if (((sel == 0) ? !busy_a : !busy_b) && q_size(sel) == 0) done = 1'b1;
        end
        check($sformatf("dut%0d_idle", sel), done, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_txd_a"}, txd_a, 1);
        check({tag, "_ready_a"}, tx_ready_a, 1);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_count_a"}, fifo_count_a, 0);
        check({tag, "_txd_b"}, txd_b, 1);
        check({tag, "_ready_b"}, tx_ready_b, 1);
        check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_count_b"}, fifo_count_b, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [6];
        exp_t       e;
        int         acc;
        int         lows;
        bit         ok;

        // Reset values, during and after reset.
        repeat (3) @(posedge clk);
        #2;
        check_reset_state("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_reset_state("after_reset");

        // 8N1, divisor 4, 0x55.
        load_div(0, 20'd4);
        push(0, 8'h55, 4, 1'b1, 1'b0);
        wait_idle(0, 200);

        // 8E2, divisor 3, 0x07: parity bit 1, 36-clock frame.
        load_div(1, 20'd3);
        push(1, 8'h07, 3, 1'b1, 1'b0);
        wait_idle(1, 200);

        // Backpressure: six words with tx_valid held high.
        words = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'hE5};
        load_div(0, 20'd4);
        acc = 0;
        tx_data_a  = words[0];
        tx_valid_a = 1'b1;
        for (int i = 0; i < 600 && acc < 6; i++) begin
            ok = tx_ready_a;
            @(posedge clk); #2;
            if (ok) begin
                e.data = words[acc]; e.div = 4; e.b2b = (acc != 0);
                e.lat_ref = (acc == 0) ? cycle : -1;
                q_a.push_back(e);
                acc++;
                if (acc < 6) tx_data_a = words[acc];
            end
            if (i == 4) begin
                check("bp_accepted", acc, 5);
                check("bp_ready", tx_ready_a, 0);
                check("bp_count", fifo_count_a, 4);
                check("bp_busy", busy_a, 1);
            end
        end
        tx_valid_a = 1'b0;
        check("bp_all_accepted", acc, 6);
        wait_idle(0, 600);

        // Divisor change mid-frame only affects the following frame.
        load_div(0, 20'd8);
        push(0, 8'hA3, 8, 1'b1, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        load_div(0, 20'd4);
        push(0, 8'hB4, 4, 1'b0, 1'b1);
        wait_idle(0, 400);

        // Divisor clamp: 0 becomes 2.
        load_div(0, 20'd0);
        push(0, 8'hFF, 2, 1'b1, 1'b0);
        wait_idle(0, 100);

        // Reset in the middle of data bit 3 with two words still queued.
        load_div(0, 20'd4);
        push(0, 8'h11, 4, 1'b1, 1'b0);
        push(0, 8'h22, 4, 1'b0, 1'b1);
        push(0, 8'h33, 4, 1'b0, 1'b1);
        check("mid_count_before", fifo_count_a, 2);
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        q_a.delete();
        @(posedge clk); #2;
        check("mid_txd", txd_a, 1);
        check("mid_count", fifo_count_a, 0);
        check("mid_busy", busy_a, 0);
        check("mid_ready", tx_ready_a, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (txd_a !== 1'b1) lows++;
        end
        check("mid_no_frames", lows, 0);
        check("mid_busy_after", busy_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Synthesizable, parametrised UART transmitter. It is the next generation of the behavioural serial driver used on the bench. It takes parallel words through a valid/ready handshake and buffers them in a small FIFO. Each word is serialised LSB-first with a configurable frame: start bit, DATA_BITS data bits, optional parity, and 1 or 2 stop bits. The bit period is set in clock cycles and can be changed at runtime. It sits between the host-side command logic and the board TX pin, and can also drive RX blocks in simulation.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz
- BAUD_RATE, 9_600, default baud; default divisor = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE
- DATA_BITS, 8, data bits per frame, legal range 5..9
- PARITY, PAR_NONE, one of PAR_NONE, PAR_ODD, PAR_EVEN (from uart_pkg)
- STOP_BITS, 1, legal values 1 or 2
- FIFO_DEPTH, 4, number of FIFO words; power of two, ≥2
- DIV_W, 20, width of the bit-period divisor

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  reset, **synchronous, active-low**
- tx_data  in  DATA_BITS  word to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  FIFO can accept a word (registered, equals !full)
- div_load  in  1  pulse: latch div_value as the new bit period
- div_value  in  DIV_W  new bit period in clocks
- txd  out  1  serial output; idle high
- busy  out  1  a frame is in progress, or the FIFO is not empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **Push:** a word is accepted on a rising edge where tx_valid && tx_ready. A word offered while tx_ready=0 is not accepted and is not lost; the source holds it.
- **Divisor register:**
  - Reset value is the default divisor.
  - div_load writes div_value into it. Values below 2 are clamped to 2.
  - The FSM samples the divisor at frame start (IDLE→START). A load during a frame affects the next frame only.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If the FIFO is not empty: pop the word into the shift register, load the bit counter, go to START.
  - START: txd=0 for div clocks, then go to DATA.
  - DATA: txd=shift[0] for div clocks per bit. Shift right after each bit. After DATA_BITS bits, go to PARITY (if enabled) or STOP.
  - PARITY: txd = ^data for even parity, ~^data for odd parity. Lasts div clocks.
  - STOP: txd=1 for STOP_BITS×div clocks. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- **Simultaneous push and pop:** both happen in the same cycle. Occupancy is unchanged. A push into a full FIFO is impossible because tx_ready=0. A push when the FIFO is full but a pop happens that cycle is still refused, because tx_ready is registered.
- **Parity:** computed over the full DATA_BITS word latched at pop.

## Timing
- **Reset values:** txd=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, divisor=default.
- **Reset mid-frame:** txd=1 on the edge where rst_n is sampled low. The FIFO is flushed. There is no partial-frame completion.
- **Latency:** a word accepted at edge N into an empty, idle block drives txd=0 starting at edge N+2. (N+1: FIFO not empty is visible; N+2: the FSM has popped and registered txd.)
- **Frame length:** exactly (1 + DATA_BITS + parity_en + STOP_BITS) × div clocks.
- **Back-to-back frames:** the next start bit begins on the clock immediately after the last stop-bit clock.
- **Registered outputs:** txd, tx_ready, fifo_count, and busy are all registers. No combinational path runs from any input to any output.
- **Counters:**
  - The bit-period counter is DIV_W bits, counts div-1 down to 0, and wraps on reload.
  - The bit index counter is $clog2(DATA_BITS+1) bits.
  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the MSB.

## Structure
- **uart_pkg:** parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN), tx_state_e enum, and the function calc_div(clk_freq, baud). This package is shared with the future RX block.
- **uart_sync_fifo:** a sub-module instantiated once. Parameters WIDTH and DEPTH. Ports: push, pop, din, dout, full, empty, count. It has a first-word-fall-through output.
- **uart_tx_core top:** holds the divisor register, the FSM, the shift register, and the parity logic.

## Test plan
- **Basic 8N1 frame:** divisor loaded as 4, 8N1, push 0x55. txd must be 0,1,0,1,0,1,0,1,0,1, each level held for 4 clocks, 40 clocks total. The start bit must begin 2 clocks after acceptance.
- **Even parity, 2 stop bits:** PARITY=PAR_EVEN, STOP_BITS=2, divisor 3, push 0x07. After the data bits, txd must carry a parity bit of 1, then two stop bits. Frame length 36 clocks.
- **Backpressure:** FIFO_DEPTH=4, push 6 words back-to-back with tx_valid held high. Exactly 5 words are accepted (1 popped, 4 buffered), then tx_ready=0. All 6 words are eventually sent in order, with no idle gap between frames.
- **Divisor update:** load divisor 8, push 0xA3, then pulse div_load with 4 during DATA. The first frame keeps 8 clocks per bit. A second pushed word uses 4 clocks per bit.
- **Reset mid-frame:** with 3 words queued, assert rst_n=0 during bit 3. On the next edge: txd=1, fifo_count=0, busy=0, tx_ready=1. No further frames are sent after release.
- **Divisor clamp:** load divisor 0, push 0xFF. Each bit lasts 2 clocks.
